// File: rtl/trap_ctrl_pkg.sv
// Shared core definitions for the trap controller: exception cause codes,
// FSM state encoding and the machine-mode CSR addresses the trap path targets.
package trap_ctrl_pkg;

  localparam logic [4:0] CAUSE_IF_MISALIGN = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK      = 5'd3;
  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_M     = 5'd11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RET   = 2'd3
  } trap_state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  cause;
    logic [31:0] pc;
    logic [31:0] val;
  } trap_info_t;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks the oldest pending exception, pulses the
// CSR file, flushes the pipeline for DRAIN_CYCLES and redirects fetch.
//   state    | meaning
//   ST_IDLE  | sampling exceptions / MRET, flush low
//   ST_ENTER | trap_entry pulse, trap fields valid, flush high
//   ST_DRAIN | flush high, down-counter runs, last cycle redirects to trap_vector
//   ST_RET   | MRET pulse with redirect to mepc_in
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_misalign,
  input  logic [31:0] if_pc,
  input  logic        id_illegal,
  input  logic        id_ecall,
  input  logic        id_ebreak,
  input  logic        id_mret,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic        mem_ld_misalign,
  input  logic        mem_st_misalign,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_addr,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mepc_in,
  output logic        trap_entry,
  output logic [31:0] trap_pc,
  output logic [4:0]  trap_cause,
  output logic [31:0] trap_val,
  output logic        mret,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  // Counter holds the number of DRAIN cycles still to follow the current one.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  trap_state_t state;
  logic [3:0]  drain_cnt;
  trap_info_t  exc;

  always_comb begin
    exc = '0;
    if (mem_ld_misalign) begin
      exc = '{valid: 1'b1, cause: CAUSE_LD_MISALIGN, pc: mem_pc, val: mem_addr};
    end else if (mem_st_misalign) begin
      exc = '{valid: 1'b1, cause: CAUSE_ST_MISALIGN, pc: mem_pc, val: mem_addr};
    end else if (id_illegal) begin
      exc = '{valid: 1'b1, cause: CAUSE_ILLEGAL, pc: id_pc, val: id_instr};
    end else if (id_ebreak) begin
      exc = '{valid: 1'b1, cause: CAUSE_EBREAK, pc: id_pc, val: 32'd0};
    end else if (id_ecall) begin
      exc = '{valid: 1'b1, cause: CAUSE_ECALL_M, pc: id_pc, val: 32'd0};
    end else if (if_misalign) begin
      exc = '{valid: 1'b1, cause: CAUSE_IF_MISALIGN, pc: if_pc, val: if_pc};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      drain_cnt      <= 4'd0;
      trap_entry     <= 1'b0;
      trap_pc        <= 32'd0;
      trap_cause     <= 5'd0;
      trap_val       <= 32'd0;
      mret           <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      trap_entry     <= 1'b0;
      mret           <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exc.valid) begin
            state      <= ST_ENTER;
            trap_entry <= 1'b1;
            flush      <= 1'b1;
            trap_pc    <= exc.pc;
            trap_cause <= exc.cause;
            trap_val   <= exc.val;
          end else if (id_mret) begin
            state          <= ST_RET;
            mret           <= 1'b1;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc_in;
          end
        end
        ST_ENTER: begin
          state     <= ST_DRAIN;
          drain_cnt <= DRAIN_LOAD;
          if (DRAIN_LOAD == 4'd0) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= trap_vector;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
            if (drain_cnt == 4'd1) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= trap_vector;
            end
          end
        end
        ST_RET: begin
          state <= ST_IDLE;
          flush <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus a randomized run against a
// schedule-based reference model; three instances cover DRAIN_CYCLES 1, 2, 15.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_misalign, id_illegal, id_ecall, id_ebreak, id_mret;
  logic        mem_ld_misalign, mem_st_misalign;
  logic [31:0] if_pc, id_pc, id_instr, mem_pc, mem_addr, trap_vector, mepc_in;

  logic        te2, mr2, fl2, rv2;
  logic [31:0] tpc2, tval2, rpc2;
  logic [4:0]  tc2;
  logic        te1, mr1, fl1, rv1;
  logic [31:0] tpc1, tval1, rpc1;
  logic [4:0]  tc1;
  logic        te15, mr15, fl15, rv15;
  logic [31:0] tpc15, tval15, rpc15;
  logic [4:0]  tc15;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.DRAIN_CYCLES(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .if_misalign(if_misalign), .if_pc(if_pc),
    .id_illegal(id_illegal), .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_mret(id_mret),
    .id_pc(id_pc), .id_instr(id_instr), .mem_ld_misalign(mem_ld_misalign),
    .mem_st_misalign(mem_st_misalign), .mem_pc(mem_pc), .mem_addr(mem_addr),
    .trap_vector(trap_vector), .mepc_in(mepc_in), .trap_entry(te2), .trap_pc(tpc2),
    .trap_cause(tc2), .trap_val(tval2), .mret(mr2), .flush(fl2),
    .redirect_valid(rv2), .redirect_pc(rpc2));

  trap_ctrl #(.DRAIN_CYCLES(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .if_misalign(if_misalign), .if_pc(if_pc),
    .id_illegal(id_illegal), .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_mret(id_mret),
    .id_pc(id_pc), .id_instr(id_instr), .mem_ld_misalign(mem_ld_misalign),
    .mem_st_misalign(mem_st_misalign), .mem_pc(mem_pc), .mem_addr(mem_addr),
    .trap_vector(trap_vector), .mepc_in(mepc_in), .trap_entry(te1), .trap_pc(tpc1),
    .trap_cause(tc1), .trap_val(tval1), .mret(mr1), .flush(fl1),
    .redirect_valid(rv1), .redirect_pc(rpc1));

  trap_ctrl #(.DRAIN_CYCLES(15)) u_d15 (
    .clk(clk), .reset_n(reset_n), .if_misalign(if_misalign), .if_pc(if_pc),
    .id_illegal(id_illegal), .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_mret(id_mret),
    .id_pc(id_pc), .id_instr(id_instr), .mem_ld_misalign(mem_ld_misalign),
    .mem_st_misalign(mem_st_misalign), .mem_pc(mem_pc), .mem_addr(mem_addr),
    .trap_vector(trap_vector), .mepc_in(mepc_in), .trap_entry(te15), .trap_pc(tpc15),
    .trap_cause(tc15), .trap_val(tval15), .mret(mr15), .flush(fl15),
    .redirect_valid(rv15), .redirect_pc(rpc15));

  // Reference model: an accepted event expands into a per-cycle list of expected outputs.
  typedef struct {
    logic        entry;
    logic        mret;
    logic        flush;
    logic        redir;
    logic        use_tv;
    logic [31:0] rpc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          cur_idle;
  logic [4:0]  m_cause;
  logic [31:0] m_pc, m_val;

  task automatic model_reset();
    exp_q.delete();
    cur      = '{default: '0};
    cur_idle = 1'b1;
    m_cause  = 5'd0;
    m_pc     = 32'd0;
    m_val    = 32'd0;
  endtask

  task automatic model_edge(input int drain);
    logic        flags[6];
    logic [4:0]  causes[6];
    logic [31:0] pcs[6];
    logic [31:0] vals[6];
    bit          taken;
    flags  = '{mem_ld_misalign, mem_st_misalign, id_illegal, id_ebreak, id_ecall, if_misalign};
    causes = '{5'd4, 5'd6, 5'd2, 5'd3, 5'd11, 5'd0};
    pcs    = '{mem_pc, mem_pc, id_pc, id_pc, id_pc, if_pc};
    vals   = '{mem_addr, mem_addr, id_instr, 32'd0, 32'd0, if_pc};
    taken  = 1'b0;
    if (cur_idle) begin
      for (int i = 0; i < 6; i++) begin
        if (!taken && flags[i]) begin
          taken   = 1'b1;
          m_cause = causes[i];
          m_pc    = pcs[i];
          m_val   = vals[i];
        end
      end
      if (taken) begin
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
        for (int k = 1; k <= drain; k++)
          exp_q.push_back('{1'b0, 1'b0, 1'b1, k == drain, k == drain, 32'd0});
      end else if (id_mret) begin
        exp_q.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, mepc_in});
      end
    end
    if (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      cur_idle = 1'b0;
      if (cur.use_tv) cur.rpc = trap_vector;
    end else begin
      cur      = '{default: '0};
      cur_idle = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    if_misalign = 0; id_illegal = 0; id_ecall = 0; id_ebreak = 0; id_mret = 0;
    mem_ld_misalign = 0; mem_st_misalign = 0;
    if_pc = 0; id_pc = 0; id_instr = 0; mem_pc = 0; mem_addr = 0;
    trap_vector = 0; mepc_in = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({te2, mr2, fl2, rv2, tc2, tpc2, tval2, rpc2} !== '0) begin
      n_fail++;
      $display("FAIL reset_d2: got te=%b mret=%b flush=%b rv=%b cause=%0d pc=%h val=%h rpc=%h, want all 0",
               te2, mr2, fl2, rv2, tc2, tpc2, tval2, rpc2);
    end
    n_checks++;
    if ({te1, mr1, fl1, rv1, tc1, tpc1, tval1, rpc1, te15, mr15, fl15, rv15, tc15, tpc15, tval15, rpc15} !== '0) begin
      n_fail++;
      $display("FAIL reset_d1_d15: outputs not all 0 (rv1=%b fl1=%b rv15=%b fl15=%b)", rv1, fl1, rv15, fl15);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    id_illegal = 1; id_pc = 32'h100; id_instr = 32'hFFFF_FFFF; trap_vector = 32'h80;
    @(negedge clk);
    id_illegal = 0;
    n_checks++;
    if (te2 !== 1 || fl2 !== 1 || tc2 !== 5'd2 || tpc2 !== 32'h100 || tval2 !== 32'hFFFF_FFFF || rv2 !== 0) begin
      n_fail++;
      $display("FAIL illegal_enter: got te=%b fl=%b cause=%0d pc=%h val=%h rv=%b, want 1 1 2 100 ffffffff 0",
               te2, fl2, tc2, tpc2, tval2, rv2);
    end
    @(negedge clk);
    n_checks++;
    if (te2 !== 0 || fl2 !== 1 || rv2 !== 0) begin
      n_fail++;
      $display("FAIL illegal_drain1: got te=%b fl=%b rv=%b, want 0 1 0", te2, fl2, rv2);
    end
    @(negedge clk);
    n_checks++;
    if (rv2 !== 1 || rpc2 !== 32'h80 || fl2 !== 1) begin
      n_fail++;
      $display("FAIL illegal_redirect: got rv=%b rpc=%h fl=%b, want 1 80 1", rv2, rpc2, fl2);
    end
    @(negedge clk);
    n_checks++;
    if (rv2 !== 0 || fl2 !== 0 || tc2 !== 5'd2 || tpc2 !== 32'h100 || tval2 !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL illegal_idle_hold: got rv=%b fl=%b cause=%0d pc=%h val=%h, want 0 0 2 100 ffffffff",
               rv2, fl2, tc2, tpc2, tval2);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    mem_ld_misalign = 1; mem_pc = 32'h200; mem_addr = 32'h1003;
    id_ecall = 1; id_pc = 32'h204;
    @(negedge clk);
    clear_inputs();
    n_checks++;
    if (te2 !== 1 || tc2 !== 5'd4 || tpc2 !== 32'h200 || tval2 !== 32'h1003) begin
      n_fail++;
      $display("FAIL priority_ld_over_ecall: got te=%b cause=%0d pc=%h val=%h, want 1 4 200 1003",
               te2, tc2, tpc2, tval2);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mret();
    apply_reset();
    id_mret = 1; mepc_in = 32'h44;
    @(negedge clk);
    id_mret = 0;
    n_checks++;
    if (mr2 !== 1 || fl2 !== 1 || rv2 !== 1 || rpc2 !== 32'h44 || te2 !== 0) begin
      n_fail++;
      $display("FAIL mret_pulse: got mret=%b fl=%b rv=%b rpc=%h te=%b, want 1 1 1 44 0",
               mr2, fl2, rv2, rpc2, te2);
    end
    @(negedge clk);
    n_checks++;
    if (mr2 !== 0 || fl2 !== 0 || rv2 !== 0 || te2 !== 0) begin
      n_fail++;
      $display("FAIL mret_after: got mret=%b fl=%b rv=%b te=%b, want 0 0 0 0", mr2, fl2, rv2, te2);
    end
    // MRET together with an exception must yield only the trap
    id_mret = 1; mepc_in = 32'h44; if_misalign = 1; if_pc = 32'h302;
    @(negedge clk);
    clear_inputs();
    n_checks++;
    if (mr2 !== 0 || te2 !== 1 || tc2 !== 5'd0 || tpc2 !== 32'h302 || tval2 !== 32'h302) begin
      n_fail++;
      $display("FAIL mret_dropped: got mret=%b te=%b cause=%0d pc=%h val=%h, want 0 1 0 302 302",
               mr2, te2, tc2, tpc2, tval2);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int pulses;
    apply_reset();
    pulses = 0;
    id_illegal = 1; id_pc = 32'h500; id_instr = 32'h1234_5678;
    @(negedge clk);
    pulses += int'(te2);
    id_illegal = 0; id_ecall = 1; id_pc = 32'h600;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(te2);
    end
    id_ecall = 0;
    n_checks++;
    if (pulses != 1 || tc2 !== 5'd2 || tpc2 !== 32'h500 || fl2 !== 0) begin
      n_fail++;
      $display("FAIL ignore_busy: got pulses=%0d cause=%0d pc=%h fl=%b, want 1 2 500 0",
               pulses, tc2, tpc2, fl2);
    end
    @(negedge clk);
    n_checks++;
    if (te2 !== 0) begin
      n_fail++;
      $display("FAIL ignore_busy_late: got te=%b, want 0", te2);
    end
    id_ecall = 1; id_pc = 32'h700;
    @(negedge clk);
    id_ecall = 0;
    n_checks++;
    if (te2 !== 1 || tc2 !== 5'd11 || tval2 !== 32'd0 || tpc2 !== 32'h700) begin
      n_fail++;
      $display("FAIL ecall_idle: got te=%b cause=%0d val=%h pc=%h, want 1 11 0 700", te2, tc2, tval2, tpc2);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_drain();
    int bad;
    apply_reset();
    id_ebreak = 1; id_pc = 32'h800; trap_vector = 32'h90;
    @(negedge clk);
    id_ebreak = 0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({te2, mr2, fl2, rv2, tc2, tpc2, tval2, rpc2} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_drain: got te=%b fl=%b rv=%b cause=%0d pc=%h, want all 0", te2, fl2, rv2, tc2, tpc2);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (te2 !== 0 || rv2 !== 0 || mr2 !== 0 || fl2 !== 0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_abandon: got %0d cycles with activity after release, want 0", bad);
    end
  endtask

  task automatic test_latency();
    int lat1, lat2, lat15;
    apply_reset();
    lat1 = -1; lat2 = -1; lat15 = -1;
    id_ecall = 1; id_pc = 32'h40; trap_vector = 32'hA0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      id_ecall = 0;
      if (rv1 === 1 && lat1 < 0) lat1 = cyc;
      if (rv2 === 1 && lat2 < 0) lat2 = cyc;
      if (rv15 === 1 && lat15 < 0) lat15 = cyc;
    end
    n_checks++;
    if (lat1 != 2 || lat2 != 3 || lat15 != 16) begin
      n_fail++;
      $display("FAIL latency: got d1=%0d d2=%0d d15=%0d, want 2 3 16 (-1 = no redirect in 30 cycles)",
               lat1, lat2, lat15);
    end
    n_checks++;
    if (rpc15 !== 32'hA0 || fl15 !== 0) begin
      n_fail++;
      $display("FAIL latency_d15_target: got rpc=%h fl=%b, want a0 0", rpc15, fl15);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      mem_ld_misalign = ($urandom_range(0, 99) < 4);
      mem_st_misalign = ($urandom_range(0, 99) < 4);
      id_illegal      = ($urandom_range(0, 99) < 4);
      id_ebreak       = ($urandom_range(0, 99) < 4);
      id_ecall        = ($urandom_range(0, 99) < 4);
      if_misalign     = ($urandom_range(0, 99) < 4);
      id_mret         = ($urandom_range(0, 99) < 15);
      if_pc = $urandom; id_pc = $urandom; id_instr = $urandom; mem_pc = $urandom;
      mem_addr = $urandom; trap_vector = $urandom; mepc_in = $urandom;
      @(posedge clk);
      model_edge(2);
      @(negedge clk);
      n_checks++;
      if (te2 !== cur.entry || mr2 !== cur.mret || fl2 !== cur.flush || rv2 !== cur.redir) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: got te=%b mret=%b fl=%b rv=%b, want %b %b %b %b",
                 cyc, te2, mr2, fl2, rv2, cur.entry, cur.mret, cur.flush, cur.redir);
      end
      if (cur.redir) begin
        n_checks++;
        if (rpc2 !== cur.rpc) begin
          n_fail++;
          $display("FAIL rand_rpc cyc %0d: got %h, want %h", cyc, rpc2, cur.rpc);
        end
      end
      n_checks++;
      if (tc2 !== m_cause || tpc2 !== m_pc || tval2 !== m_val) begin
        n_fail++;
        $display("FAIL rand_fields cyc %0d: got cause=%0d pc=%h val=%h, want %0d %h %h",
                 cyc, tc2, tpc2, tval2, m_cause, m_pc, m_val);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_illegal();
    test_priority();
    test_mret();
    test_ignore_busy();
    test_reset_in_drain();
    test_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
